// File: rtl/fp16_exp_combine.sv
// fp16_exp_combine: 2-stage FP16 multiplier joining the partial-exp factors.
// Define SOFTMAX_SUM_EN for a saturating Q.16 per-vector sum of the results.
module fp16_exp_combine #(
  parameter int ACC_W = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_exp,
  input  logic [15:0]      in_mant,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
`ifdef SOFTMAX_SUM_EN
  output logic             out_last,
  output logic             sum_valid,
  output logic [ACC_W-1:0] sum_data
`else
  output logic             out_last
`endif
);

  logic s2_en, s1_en;

  logic        s1_valid;
  logic        s1_sign;
  logic        s1_last;
  logic        s1_spec;
  logic [15:0] s1_spec_data;
  logic [21:0] s1_prod;
  logic [6:0]  s1_exp;

  assign s2_en    = !out_valid || out_ready;
  assign s1_en    = !s1_valid || s2_en;
  assign in_ready = !rst && s1_en;

  logic [4:0]  ea, eb;
  logic [9:0]  ma, mb;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic        sign_c, spec_c;
  logic [15:0] spec_data_c;
  logic [21:0] prod_c;
  logic [6:0]  exp_c;

  assign ea = in_exp[14:10];
  assign eb = in_mant[14:10];
  assign ma = in_exp[9:0];
  assign mb = in_mant[9:0];

  assign a_nan  = (&ea) && (|ma);
  assign b_nan  = (&eb) && (|mb);
  assign a_inf  = (&ea) && !(|ma);
  assign b_inf  = (&eb) && !(|mb);
  assign a_zero = (ea == 5'd0);
  assign b_zero = (eb == 5'd0);

  assign sign_c = in_exp[15] ^ in_mant[15];
  assign prod_c = 22'({1'b1, ma}) * 22'({1'b1, mb});
  assign exp_c  = {2'b00, ea} + {2'b00, eb} - 7'd15;

  // Special cases resolved up front, highest priority first
  always_comb begin
    spec_c      = 1'b1;
    spec_data_c = 16'h7E00;
    if (a_nan || b_nan) begin
      spec_data_c = 16'h7E00;
    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      spec_data_c = 16'h7E00;
    end else if (a_inf || b_inf) begin
      spec_data_c = {sign_c, 15'h7C00};
    end else if (a_zero || b_zero) begin
      spec_data_c = {sign_c, 15'h0000};
    end else begin
      spec_c      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (s1_en) begin
      s1_valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (s1_en && in_valid && !rst) begin
      s1_sign      <= sign_c;
      s1_last      <= in_last;
      s1_spec      <= spec_c;
      s1_spec_data <= spec_data_c;
      s1_prod      <= prod_c;
      s1_exp       <= exp_c;
    end
  end

  logic        hi, guard, sticky, rnd;
  logic [9:0]  m10;
  logic [10:0] m11;
  logic [7:0]  e1, e2;
  logic [9:0]  mant_r;
  logic [15:0] res;

  assign hi     = s1_prod[21];
  assign m10    = hi ? s1_prod[20:11] : s1_prod[19:10];
  assign guard  = hi ? s1_prod[10] : s1_prod[9];
  assign sticky = hi ? (|s1_prod[9:0]) : (|s1_prod[8:0]);
  assign rnd    = guard && (sticky || m10[0]);
  assign m11    = {1'b0, m10} + {10'd0, rnd};
  assign e1     = {s1_exp[6], s1_exp} + {7'd0, hi};
  // Rounding carry out of the mantissa bumps the exponent
  assign e2     = e1 + {7'd0, m11[10]};
  assign mant_r = m11[10] ? 10'd0 : m11[9:0];

  always_comb begin
    res = {s1_sign, e2[4:0], mant_r};
    if (s1_spec) begin
      res = s1_spec_data;
    end else if ($signed(e2) >= 8'sd31) begin
      res = {s1_sign, 15'h7C00};
    end else if ($signed(e2) <= 8'sd0) begin
      res = {s1_sign, 15'h0000};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= 16'h0000;
      out_last  <= 1'b0;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= res;
        out_last <= s1_last;
      end
    end
  end

`ifdef SOFTMAX_SUM_EN
  logic             fire;
  logic [4:0]       oe;
  logic [ACC_W-1:0] mext, q, acc, sat;
  logic [ACC_W:0]   add;

  assign fire = out_valid && out_ready;
  assign oe   = out_data[14:10];
  assign mext = {{(ACC_W-11){1'b0}}, 1'b1, out_data[9:0]};

  // FP16 to unsigned Q.16, truncating; value = mext * 2^(oe-9) in Q.16
  always_comb begin
    q = '0;
    if ((&oe) && (|out_data[9:0])) begin
      q = '1;
    end else if (out_data[15]) begin
      q = '0;
    end else if (&oe) begin
      q = '1;
    end else if (oe == 5'd0) begin
      q = '0;
    end else if (oe >= 5'd9) begin
      q = mext << (oe - 5'd9);
    end else begin
      q = mext >> (5'd9 - oe);
    end
  end

  assign add = {1'b0, acc} + {1'b0, q};
  assign sat = add[ACC_W] ? '1 : add[ACC_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      sum_valid <= 1'b0;
      sum_data  <= '0;
    end else begin
      sum_valid <= 1'b0;
      if (fire) begin
        if (out_last) begin
          sum_data  <= sat;
          sum_valid <= 1'b1;
          acc       <= '0;
        end else begin
          acc <= sat;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_fp16_exp_combine.sv
// tb_fp16_exp_combine: directed and randomized checks of fp16_exp_combine
// against a real-arithmetic FP16 multiply model.
module tb_fp16_exp_combine;
  localparam int ACC_W = 40;
  localparam longint SAT = (longint'(1) << ACC_W) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_exp = 16'h0;
  logic [15:0] in_mant = 16'h0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_last;
`ifdef SOFTMAX_SUM_EN
  logic             sum_valid;
  logic [ACC_W-1:0] sum_data;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp16_exp_combine #(.ACC_W(ACC_W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_exp(in_exp),
    .in_mant(in_mant),
    .in_last(in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
`ifdef SOFTMAX_SUM_EN
    .out_last(out_last),
    .sum_valid(sum_valid),
    .sum_data(sum_data)
`else
    .out_last(out_last)
`endif
  );

  function automatic real fp_mag(input logic [15:0] x);
    real v;
    int  e;
    v = 1.0 + real'(x[9:0]) / 1024.0;
    e = int'(x[14:10]) - 15;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return v;
  endfunction

  function automatic logic [15:0] model_mul(input logic [15:0] a,
                                            input logic [15:0] b);
    logic   s, an, bn, ai, bi, az, bz;
    real    p, fr;
    int     e, be;
    longint fl;
    s  = a[15] ^ b[15];
    an = (a[14:10] == 5'd31) && (a[9:0] != 10'd0);
    bn = (b[14:10] == 5'd31) && (b[9:0] != 10'd0);
    ai = (a[14:10] == 5'd31) && (a[9:0] == 10'd0);
    bi = (b[14:10] == 5'd31) && (b[9:0] == 10'd0);
    az = (a[14:10] == 5'd0);
    bz = (b[14:10] == 5'd0);
    if (an || bn) return 16'h7E00;
    if ((ai && bz) || (bi && az)) return 16'h7E00;
    if (ai || bi) return {s, 15'h7C00};
    if (az || bz) return {s, 15'h0000};
    p = fp_mag(a) * fp_mag(b);
    e = 0;
    while (p >= 2.0) begin p = p / 2.0; e++; end
    while (p < 1.0) begin p = p * 2.0; e--; end
    fl = longint'($floor(p * 1024.0));
    fr = p * 1024.0 - real'(fl);
    if (fr > 0.5 || (fr == 0.5 && (fl % 2) == 1)) fl++;
    if (fl == 2048) begin fl = 1024; e++; end
    be = e + 15;
    if (be >= 31) return {s, 15'h7C00};
    if (be <= 0) return {s, 15'h0000};
    return {s, 5'(be), 10'(fl)};
  endfunction

  function automatic longint model_q16(input logic [15:0] x);
    if (x[14:10] == 5'd31 && x[9:0] != 10'd0) return SAT;
    if (x[15]) return 0;
    if (x[14:10] == 5'd31) return SAT;
    if (x[14:10] == 5'd0) return 0;
    return longint'($floor(fp_mag(x) * 65536.0));
  endfunction

  function automatic logic [15:0] rand_fp();
    logic [15:0] x;
    int          k;
    x = 16'($urandom);
    k = int'($urandom_range(0, 9));
    if (k < 6) x[14:10] = 5'($urandom_range(8, 22));
    else if (k == 6) x[14:10] = 5'($urandom_range(25, 31));
    else if (k == 7) x[14:10] = 5'($urandom_range(0, 6));
    return x;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_outs: valid=%b data=%h last=%b want 0 0000 0",
               out_valid, out_data, out_last);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 0", in_ready);
    end
`ifdef SOFTMAX_SUM_EN
    checks++;
    if (sum_valid !== 1'b0 || sum_data !== '0) begin
      errors++;
      $display("FAIL reset_sum: valid=%b data=%h want 0 0", sum_valid, sum_data);
    end
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: in_ready=%b out_valid=%b want 1 0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_latency();
    @(posedge clk); #1;
    in_valid = 1'b1; in_exp = 16'h3C00; in_mant = 16'h3C00; in_last = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL lat_cycle1: out_valid=%b want 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h3C00) begin
      errors++;
      $display("FAIL lat_cycle2: valid=%b data=%h want 1 3c00", out_valid, out_data);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL lat_pulse: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_arith();
    logic [15:0] ta[12] = '{16'h4000, 16'h3C01, 16'h3555, 16'h7800,
                            16'h0400, 16'h7C00, 16'h0200, 16'hC000,
                            16'h7E01, 16'hFC00, 16'h8000, 16'h7BFF};
    logic [15:0] tb[12] = '{16'h4200, 16'h3C01, 16'h4200, 16'h4000,
                            16'h3800, 16'h0000, 16'h3C00, 16'h4000,
                            16'h3C00, 16'h4000, 16'h7C00, 16'h3C00};
    logic [15:0] te[12] = '{16'h4600, 16'h3C02, 16'h3C00, 16'h7C00,
                            16'h0000, 16'h7E00, 16'h0000, 16'hC400,
                            16'h7E00, 16'hFC00, 16'h7E00, 16'h7BFF};
    int t;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_exp = ta[i]; in_mant = tb[i]; in_last = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!out_valid && t < 10);
      checks++;
      if (out_valid !== 1'b1 || out_data !== te[i] || t != 2) begin
        errors++;
        $display("FAIL arith_%0d %h*%h: got %h after %0d cycles want %h after 2",
                 i, ta[i], tb[i], out_data, t, te[i]);
      end
      checks++;
      if (out_data !== model_mul(ta[i], tb[i])) begin
        errors++;
        $display("FAIL arith_model_%0d: got %h want %h",
                 i, out_data, model_mul(ta[i], tb[i]));
      end
    end
  endtask

  task automatic test_stall();
    logic [15:0] lst[5] = '{16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600};
    int sent, got, c;
    logic hold, seen_block, fire_in;
    logic [15:0] hold_d;
    sent = 0; got = 0; c = 0; hold = 0; seen_block = 0; hold_d = 16'h0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_exp = 16'h3C00; in_mant = lst[0]; in_last = 1'b0;
    out_ready = 1'b1;
    while (got < 5 && c < 40) begin
      @(negedge clk);
      if (hold) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== hold_d) begin
          errors++;
          $display("FAIL stall_hold: valid=%b data=%h want 1 %h",
                   out_valid, out_data, hold_d);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (out_data !== lst[got]) begin
          errors++;
          $display("FAIL stall_order_%0d: got %h want %h", got, out_data, lst[got]);
        end
        got++;
      end
      if (in_valid && !in_ready) seen_block = 1'b1;
      hold = out_valid && !out_ready;
      hold_d = out_data;
      fire_in = in_valid && in_ready;
      @(posedge clk); #1;
      c++;
      if (fire_in) begin
        sent++;
        if (sent < 5) in_mant = lst[sent];
        else in_valid = 1'b0;
      end
      out_ready = !(c >= 2 && c <= 6);
    end
    checks++;
    if (got != 5 || !seen_block) begin
      errors++;
      $display("FAIL stall_count: got %0d blocked=%b want 5 1", got, seen_block);
    end
    in_valid = 1'b0;
    got = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) got++;
    end
    checks++;
    if (got != 0) begin
      errors++;
      $display("FAIL stall_dup: extra outputs %0d want 0", got);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; in_exp = 16'h4000; in_mant = 16'h3C00; in_last = 1'b0;
    @(posedge clk); #1;
    in_mant = 16'h4200;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_flush: out_valid=%b want 0", out_valid);
    end
    n = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL rstmid_ghost: outputs %0d want 0", n);
    end
    @(posedge clk); #1;
    in_valid = 1'b1; in_exp = 16'h4000; in_mant = 16'h4000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) begin
        n++;
        checks++;
        if (out_data !== 16'h4400) begin
          errors++;
          $display("FAIL rstmid_data: got %h want 4400", out_data);
        end
      end
    end
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL rstmid_count: outputs %0d want 1", n);
    end
  endtask

`ifdef SOFTMAX_SUM_EN
  task automatic test_sum();
    logic [15:0] va;
    int n, pulses;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int v = 0; v < 2; v++) begin
      n  = (v == 0) ? 4 : 2;
      va = (v == 0) ? 16'h3C00 : 16'h4000;
      for (int i = 0; i < n; i++) begin
        in_valid = 1'b1; in_exp = va; in_mant = 16'h3C00; in_last = (i == n - 1);
        @(posedge clk); #1;
      end
      in_valid = 1'b0; in_last = 1'b0;
      pulses = 0;
      repeat (8) begin
        @(negedge clk);
        if (sum_valid) begin
          pulses++;
          checks++;
          if (sum_data !== 40'h0000040000) begin
            errors++;
            $display("FAIL sum_vec%0d: got %h want 0000040000", v, sum_data);
          end
        end
      end
      checks++;
      if (pulses != 1) begin
        errors++;
        $display("FAIL sum_pulse_vec%0d: pulses %0d want 1", v, pulses);
      end
    end
  endtask
`endif

  task automatic test_random(input int n);
    logic [16:0] q[$];
    logic [16:0] e;
    int sent, got, cyc;
    logic hold, fire_in, fire_out;
    logic [16:0] hold_d;
    longint acc, pend_val;
    logic pend;
    sent = 0; got = 0; cyc = 0; hold = 0; hold_d = '0;
    acc = 0; pend = 0; pend_val = 0;
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = ($urandom % 4) != 0;
    in_exp = rand_fp(); in_mant = rand_fp(); in_last = ($urandom % 5) == 0;
    out_ready = ($urandom % 3) != 0;
    while (got < n && cyc < 20 * n) begin
      @(negedge clk);
`ifdef SOFTMAX_SUM_EN
      checks++;
      if (sum_valid !== pend || (pend && sum_data !== ACC_W'(pend_val))) begin
        errors++;
        $display("FAIL rand_sum: valid=%b data=%h want %b %h",
                 sum_valid, sum_data, pend, ACC_W'(pend_val));
      end
      pend = 1'b0;
`endif
      if (hold) begin
        checks++;
        if (out_valid !== 1'b1 || {out_last, out_data} !== hold_d) begin
          errors++;
          $display("FAIL rand_hold: got %b %h want 1 %h",
                   out_valid, {out_last, out_data}, hold_d);
        end
      end
      fire_out = out_valid && out_ready;
      fire_in = in_valid && in_ready;
      if (fire_out) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rand_spurious: got %h with nothing outstanding", out_data);
        end else begin
          e = q.pop_front();
          if ({out_last, out_data} !== e) begin
            errors++;
            $display("FAIL rand_data_%0d: got %h want %h", got, {out_last, out_data}, e);
          end
          acc = acc + model_q16(e[15:0]);
          if (acc > SAT) acc = SAT;
          if (e[16]) begin
            pend = 1'b1; pend_val = acc; acc = 0;
          end
        end
        got++;
      end
      if (fire_in) q.push_back({in_last, model_mul(in_exp, in_mant)});
      hold = out_valid && !out_ready;
      hold_d = {out_last, out_data};
      @(posedge clk); #1;
      cyc++;
      if (fire_in) sent++;
      if (fire_in || !in_valid) begin
        in_valid = (sent < n) && (($urandom % 4) != 0);
        in_exp = rand_fp(); in_mant = rand_fp(); in_last = ($urandom % 5) == 0;
      end
      out_ready = ($urandom % 3) != 0;
    end
    in_valid = 1'b0;
    checks++;
    if (got != n || q.size() != 0) begin
      errors++;
      $display("FAIL rand_count: got %0d left %0d want %0d 0", got, q.size(), n);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_arith();
    test_stall();
    test_reset_mid();
`ifdef SOFTMAX_SUM_EN
    test_sum();
`endif
    test_random(400);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp16_exp_combine.md
Name: fp16_exp_combine

Overview:
Streaming back-end for the FP12 partial-exponential path. It consumes the two FP16 partial factors produced per element: exp_exp, the factor from sign+exponent, and mant_exp, the factor from the mantissa. It multiplies them to form the FP16 value exp(x) and returns the result under a valid/ready handshake. It is a 2-stage pipelined FP16 multiplier with stall support, placed between the partial-exp LUT stage and the softmax/activation datapath.

Parameters:
ACC_W, 40, accumulator width in bits for the optional sum, unsigned Q(ACC_W-16).16; only used with SOFTMAX_SUM_EN.

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept a beat this cycle
in_exp  input  16  FP16 exponent-part factor (exp_exp)
in_mant  input  16  FP16 mantissa-part factor (mant_exp)
in_last  input  1  marks the final element of a vector
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_data  output  16  FP16 product in_exp*in_mant
out_last  output  1  in_last delayed with the data
sum_valid  output  1  (SOFTMAX_SUM_EN only) one-cycle pulse with the vector sum
sum_data  output  ACC_W  (SOFTMAX_SUM_EN only) saturated fixed-point sum of the vector's results

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst). Fixed.
- Reset values: out_valid=0, out_data=0, out_last=0, sum_valid=0, sum_data=0, stage valids=0, accumulator=0.
- While rst is high, in_ready=0.
- Reset asserted mid-operation discards all in-flight beats; no output after reset deasserts until new input arrives.
- Handshake:
  - A beat transfers when valid&&ready on the same edge.
  - in_ready = !s2_valid || out_ready || !s1_valid. This is a bubble-collapsing pipeline; each stage advances when its downstream slot is empty or draining.
  - out_data and out_last hold stable while out_valid && !out_ready.
- Latency: 2 cycles from input transfer to out_valid when unstalled. Throughput is 1 beat/cycle. Order is preserved.
- Stage 1:
  - Unpack both operands.
  - Subnormal or zero operand (exp field=0) is treated as zero.
  - Compute sign = sa^sb, 22-bit mantissa product of {1,m}x{1,m}, 7-bit signed exponent ea+eb-15.
  - Capture special-case flags.
- Stage 2:
  - Normalise: if product bit21 is set, shift right 1 and add 1 to the exponent.
  - Round to nearest-even on guard/sticky. A rounding carry renormalises.
  - Pack the result.
- Special cases, in priority order:
  1. Either operand NaN -> 0x7E00.
  2. Inf times zero -> 0x7E00.
  3. Either operand Inf -> sign|0x7C00.
  4. Either operand zero -> sign|0x0000.
  5. Final exponent >= 31 -> sign|0x7C00.
  6. Final exponent <= 0 -> sign|0x0000 (flush, no subnormal output).

Optional Feature:
- Macro: SOFTMAX_SUM_EN.
- When defined:
  - Each accepted output (out_valid&&out_ready) is converted to unsigned Q.16 fixed point, truncating bits below 2^-16. Negative values contribute 0; Inf/NaN saturate.
  - The converted value is added to the accumulator with saturation at all-ones.
  - On the transfer carrying out_last=1: sum_data = accumulator including this element, sum_valid pulses for one cycle, and the accumulator clears to 0 on the same edge.
- When undefined: sum_valid and sum_data are absent and there is no accumulator logic.

Test Plan:
- Reset, then 0x3C00 x 0x3C00 with out_ready=1 -> out_data=0x3C00 exactly 2 cycles later; out_valid high for 1 cycle.
- Arithmetic and rounding:
  - 0x4000 x 0x4200 -> 0x4600.
  - 0x3C01 x 0x3C01 -> 0x3C02 (RNE).
  - 0x3555 x 0x4200 -> 0x3C00.
- Boundaries:
  - 0x7800 x 0x4000 -> 0x7C00.
  - 0x0400 x 0x3800 -> 0x0000 (flush).
  - 0x7C00 x 0x0000 -> 0x7E00.
  - 0x0200 x 0x3C00 -> 0x0000.
- Stall: stream 5 beats 0x3C00 x {0x4000,0x4200,0x4400,0x4500,0x4600} with out_ready low for cycles 2-6 -> in_ready deasserts once both stages are full; results 0x4000,0x4200,0x4400,0x4500,0x4600 emerge in order; none lost or duplicated; out_data held while stalled.
- Reset mid-stream: rst pulsed with 2 beats in flight -> out_valid=0 the cycle after reset; the next single input yields exactly one output.
- SOFTMAX_SUM_EN: four beats of 1.0 (0x3C00 x 0x3C00), last on the 4th -> sum_valid pulse with sum_data=0x0000040000. A following vector of two 0x4000 x 0x3C00 beats -> 0x0000040000 (accumulator cleared between vectors).
